binary_to_bcd_seq: RTL and testbench

Parameterised, sequential double-dabble binary-to-BCD converter. It is the successor to the fixed 8-bit combinational converter, for display and readout paths wider than 8 bits. It uses one shift-and-add-3 step per clock with a START/BUSY/DONE handshake. This trades latency for area and lets any input width drive any number of display digits, with overflow reporting.

---
 rtl/binary_to_bcd_seq.sv | 111 +++++++++++
 tb/tb_binary_to_bcd_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift-add-3 step per clock.
// Optional two's-complement input support: define BINARY_TO_BCD_SIGNED_EN.
module binary_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [BIN_W-1:0]    BIN,
    output logic                BUSY,
    output logic                DONE,
    output logic [4*DIGITS-1:0] BCD,
    output logic                OVF,
    output logic                SIGN
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [BIN_W-1:0] bin_sr;
    logic [BIN_W-1:0] bin_nx;
    logic [BIN_W-1:0] load_val;
    logic [BW-1:0]    work;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    work_nx;
    logic             work_ovf;
    logic             shift_out;
    logic [CW-1:0]    cnt;

    // Digits are adjusted independently; a digit <= 9 plus 3 never exceeds 4 bits.
    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
    end

    assign work_nx   = {adj[BW-2:0], bin_sr[BIN_W-1]};
    assign bin_nx    = {bin_sr[BIN_W-2:0], 1'b0};
    assign shift_out = adj[BW-1];

`ifdef BINARY_TO_BCD_SIGNED_EN
    logic work_sign;

    // Magnitude in BIN_W bits: the most negative value maps to 2^(BIN_W-1).
    assign load_val = BIN[BIN_W-1] ? -BIN : BIN;
`else
    assign load_val = BIN;
    assign SIGN     = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            bin_sr   <= '0;
            work     <= '0;
            work_ovf <= 1'b0;
            cnt      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            BCD      <= '0;
            OVF      <= 1'b0;
`ifdef BINARY_TO_BCD_SIGNED_EN
            work_sign <= 1'b0;
            SIGN      <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (START) begin
                        bin_sr   <= load_val;
                        work     <= '0;
                        work_ovf <= 1'b0;
                        cnt      <= CW'(BIN_W);
                        BUSY     <= 1'b1;
                        state    <= SHIFT;
`ifdef BINARY_TO_BCD_SIGNED_EN
                        work_sign <= BIN[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    work     <= work_nx;
                    bin_sr   <= bin_nx;
                    work_ovf <= work_ovf | shift_out;
                    cnt      <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        BCD   <= work_nx;
                        OVF   <= work_ovf | shift_out;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
`ifdef BINARY_TO_BCD_SIGNED_EN
                        SIGN  <= work_sign;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench for binary_to_bcd_seq: default instance plus an 8-bit/2-digit one,
// results checked through per-instance scoreboards against a division-based model.
module tb_binary_to_bcd_seq;

    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic        sgn;
    } exp_t;

    logic        CLK;
    logic        RST_N;

    logic        start16;
    logic [15:0] bin16;
    logic        busy16;
    logic        done16;
    logic [19:0] bcd16;
    logic        ovf16;
    logic        sign16;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  bcd8;
    logic        ovf8;
    logic        sign8;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q16[$];
    exp_t q8[$];
    logic [21:0] held16 = '0;
    logic [9:0]  held8  = '0;

    binary_to_bcd_seq dut16 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (start16),
        .BIN   (bin16),
        .BUSY  (busy16),
        .DONE  (done16),
        .BCD   (bcd16),
        .OVF   (ovf16),
        .SIGN  (sign16)
    );

    binary_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (start8),
        .BIN   (bin8),
        .BUSY  (busy8),
        .DONE  (done8),
        .BCD   (bcd8),
        .OVF   (ovf8),
        .SIGN  (sign8)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] bin, input int w,
                                   input int d);
        exp_t   e;
        longint m;
        longint mag;
        m     = (longint'(1) << w) - 1;
        mag   = longint'(bin) & m;
        e     = '0;
`ifdef BINARY_TO_BCD_SIGNED_EN
        if (bin[w-1]) begin
            e.sgn = 1'b1;
            mag   = ((longint'(1) << w) - mag) & m;
        end
`endif
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e.ovf = (mag != 0);
        return e;
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            held16 = '0;
        end else if (done16) begin
            if (q16.size() == 0) begin
                chk("dut16_spurious_done", 64'(done16), 64'(0));
            end else begin
                e = q16.pop_front();
                chk("dut16_bcd", 64'(bcd16), 64'(e.bcd[19:0]));
                chk("dut16_ovf", 64'(ovf16), 64'(e.ovf));
                chk("dut16_sign", 64'(sign16), 64'(e.sgn));
                held16 = {e.ovf, e.sgn, e.bcd[19:0]};
            end
        end else begin
            chk("dut16_hold", 64'({ovf16, sign16, bcd16}), 64'(held16));
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            held8 = '0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                chk("dut8_spurious_done", 64'(done8), 64'(0));
            end else begin
                e = q8.pop_front();
                chk("dut8_bcd", 64'(bcd8), 64'(e.bcd[7:0]));
                chk("dut8_ovf", 64'(ovf8), 64'(e.ovf));
                chk("dut8_sign", 64'(sign8), 64'(e.sgn));
                held8 = {e.ovf, e.sgn, e.bcd[7:0]};
            end
        end else begin
            chk("dut8_hold", 64'({ovf8, sign8, bcd8}), 64'(held8));
        end
    end

    task automatic wait_done16(output int cyc, output logic busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
            if (!done16 && !busy16) busy_ok = 1'b0;
        end while (!done16 && cyc < 40);
        chk("dut16_done_seen", 64'(done16), 64'(1));
    endtask

    task automatic conv16(input logic [15:0] v, input string tag);
        int   cyc;
        logic bok;
        bin16   = v;
        start16 = 1'b1;
        q16.push_back(model(32'(v), 16, 5));
        @(posedge CLK);
        #1;
        start16 = 1'b0;
        chk({tag, "_busy_e0"}, 64'(busy16), 64'(1));
        wait_done16(cyc, bok);
        chk({tag, "_latency"}, 64'(cyc), 64'(16));
        chk({tag, "_busy_held"}, 64'(bok), 64'(1));
        chk({tag, "_busy_clr"}, 64'(busy16), 64'(0));
    endtask

    task automatic conv8(input logic [7:0] v, input string tag);
        int cyc;
        bin8   = v;
        start8 = 1'b1;
        q8.push_back(model(32'(v), 8, 2));
        @(posedge CLK);
        #1;
        start8 = 1'b0;
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (!done8 && cyc < 30);
        chk({tag, "_latency"}, 64'(cyc), 64'(8));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int   cyc;
        logic bok;
        start16 = 1'b0;
        bin16   = '0;
        start8  = 1'b0;
        bin8    = '0;
        RST_N   = 1'b1;
        #1 RST_N = 1'b0;
        start16 = 1'b1;
        idle(3);
        chk("rst_bcd", 64'(bcd16), 64'(0));
        chk("rst_busy", 64'(busy16), 64'(0));
        chk("rst_done", 64'(done16), 64'(0));
        chk("rst_ovf", 64'(ovf16), 64'(0));
        chk("rst_sign", 64'(sign16), 64'(0));
        start16 = 1'b0;
        RST_N   = 1'b1;
        idle(2);

        conv16(16'd0, "zero");
        idle(2);
        conv16(16'hFFFF, "full");
        idle(1);
        conv16(16'd12345, "d12345");
        idle(1);
        conv16(16'h8000, "h8000");
        idle(1);
        conv16(16'h7FFF, "h7fff");
        idle(1);
        conv16(16'd1, "one");
        idle(1);

        conv8(8'd255, "ovf255");
        idle(1);
        conv8(8'd99, "n99");
        idle(1);
        conv8(8'd128, "n128");
        idle(1);

        // START held high; BIN changes mid-conversion, next START lands in DONE cycle.
        bin16   = 16'd12345;
        start16 = 1'b1;
        q16.push_back(model(32'(16'd12345), 16, 5));
        @(posedge CLK);
        repeat (5) @(posedge CLK);
        #1;
        bin16 = 16'd9;
        q16.push_back(model(32'(16'd9), 16, 5));
        wait_done16(cyc, bok);
        chk("hs_first_done", 64'(cyc), 64'(11));
        @(posedge CLK);
        #1;
        start16 = 1'b0;
        chk("hs_reaccept_busy", 64'(busy16), 64'(1));
        wait_done16(cyc, bok);
        chk("hs_second_done", 64'(cyc + 1), 64'(17));
        idle(2);

        // START pulses while busy must not queue another conversion.
        bin16   = 16'd7;
        start16 = 1'b1;
        q16.push_back(model(32'(16'd7), 16, 5));
        @(posedge CLK);
        #1;
        start16 = 1'b0;
        idle(3);
        bin16   = 16'd3;
        start16 = 1'b1;
        idle(1);
        start16 = 1'b0;
        idle(5);
        start16 = 1'b1;
        idle(1);
        start16 = 1'b0;
        wait_done16(cyc, bok);
        idle(40);
        chk("busy_pulse_queue", 64'(q16.size()), 64'(0));

        // Reset between edges 8 and 9 of a conversion.
        bin16   = 16'd12345;
        start16 = 1'b1;
        q16.push_back(model(32'(16'd12345), 16, 5));
        @(posedge CLK);
        #1;
        start16 = 1'b0;
        repeat (8) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        q16.delete();
        #1;
        chk("mid_rst_bcd", 64'(bcd16), 64'(0));
        chk("mid_rst_busy", 64'(busy16), 64'(0));
        chk("mid_rst_done", 64'(done16), 64'(0));
        chk("mid_rst_ovf", 64'(ovf16), 64'(0));
        chk("mid_rst_sign", 64'(sign16), 64'(0));
        chk("mid_rst_bcd8", 64'(bcd8), 64'(0));
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(25);
        chk("mid_rst_no_done", 64'(done16), 64'(0));
        conv16(16'd42, "after_rst");
        idle(3);

        chk("q16_empty", 64'(q16.size()), 64'(0));
        chk("q8_empty", 64'(q8.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
